// File: rtl/VX_gpu_pkg.sv
// Shared definitions for the dot8 accumulator stage: op encodings and datapath width.
package VX_gpu_pkg;

   localparam int unsigned DOT8_ACC_BITS = 32;

   typedef enum logic [1:0] {
      DOT8_ACC_PASS  = 2'd0,
      DOT8_ACC_LOAD  = 2'd1,
      DOT8_ACC_ACC   = 2'd2,
      DOT8_ACC_DRAIN = 2'd3
   } dot8_acc_op_e;

endpackage

// File: rtl/vx_dot8_accum_lane.sv
// One lane of the dot8 accumulator: combinational next-accumulator, result and overflow.
module vx_dot8_accum_lane
   import VX_gpu_pkg::*;
(
   input  dot8_acc_op_e             i_op,
   input  logic [DOT8_ACC_BITS-1:0] i_acc,
   input  logic [DOT8_ACC_BITS-1:0] i_in,
   input  logic                     i_active,
   output logic [DOT8_ACC_BITS-1:0] o_next_acc,
   output logic [DOT8_ACC_BITS-1:0] o_out,
   output logic                     o_ovf
);

   localparam int unsigned MSB = DOT8_ACC_BITS - 1;

   logic [DOT8_ACC_BITS-1:0] w_sum;
   logic                     w_ovf;

   assign w_sum = i_acc + i_in;
   // Signed overflow: same-sign operands producing an opposite-sign sum
   assign w_ovf = (i_acc[MSB] == i_in[MSB]) && (w_sum[MSB] != i_acc[MSB]);

   always_comb begin
      o_next_acc = i_acc;
      o_out      = '0;
      o_ovf      = 1'b0;
      if (i_active) begin
         unique case (i_op)
            DOT8_ACC_PASS: begin
               o_out = i_in;
            end
            DOT8_ACC_LOAD: begin
               o_next_acc = i_in;
               o_out      = i_in;
            end
            DOT8_ACC_ACC: begin
               o_next_acc = w_sum;
               o_out      = w_sum;
               o_ovf      = w_ovf;
            end
            DOT8_ACC_DRAIN: begin
               o_next_acc = '0;
               o_out      = w_sum;
               o_ovf      = w_ovf;
            end
            default: ;
         endcase
      end
   end

endmodule

// File: rtl/vx_dot8_accum.sv
// Per-warp, per-lane dot8 accumulator with a one-deep registered valid/ready output.
module vx_dot8_accum
   import VX_gpu_pkg::*;
#(
   parameter  int unsigned NUM_LANES = 4,
   parameter  int unsigned NUM_WARPS = 4,
   parameter  int unsigned TAG_WIDTH = 64,
   localparam int unsigned NW_WIDTH  = (NUM_WARPS > 1) ? $clog2(NUM_WARPS) : 1
)(
   input  logic                               clk,
   input  logic                               reset,
   input  logic                               in_valid,
   output logic                               in_ready,
   input  logic [1:0]                         in_op,
   input  logic [NW_WIDTH-1:0]                in_wid,
   input  logic [NUM_LANES-1:0]               in_tmask,
   input  logic [NUM_LANES*DOT8_ACC_BITS-1:0] in_data,
   input  logic [TAG_WIDTH-1:0]               in_tag,
   input  logic                               clr_valid,
   input  logic [NW_WIDTH-1:0]                clr_wid,
   output logic                               out_valid,
   input  logic                               out_ready,
   output logic [NW_WIDTH-1:0]                out_wid,
   output logic [NUM_LANES-1:0]               out_tmask,
   output logic [NUM_LANES*DOT8_ACC_BITS-1:0] out_data,
   output logic [NUM_LANES-1:0]               out_ovf,
   output logic [TAG_WIDTH-1:0]               out_tag,
   output logic [31:0]                        acc_count
);

   localparam int unsigned DW = NUM_LANES * DOT8_ACC_BITS;

   logic [DOT8_ACC_BITS-1:0] r_acc [NUM_WARPS][NUM_LANES];

   logic                     r_out_valid;
   logic [NW_WIDTH-1:0]      r_out_wid;
   logic [NUM_LANES-1:0]     r_out_tmask;
   logic [DW-1:0]            r_out_data;
   logic [NUM_LANES-1:0]     r_out_ovf;
   logic [TAG_WIDTH-1:0]     r_out_tag;
   logic [31:0]              r_acc_count;

   logic                     w_accept;
   logic                     w_clr_hit;
   dot8_acc_op_e             w_op;
   logic [DOT8_ACC_BITS-1:0] w_acc_cur  [NUM_LANES];
   logic [DOT8_ACC_BITS-1:0] w_next_acc [NUM_LANES];
   logic [DOT8_ACC_BITS-1:0] w_lane_out [NUM_LANES];
   logic [NUM_LANES-1:0]     w_ovf;
   logic [DW-1:0]            w_out_flat;

   assign in_ready  = !r_out_valid || out_ready;
   assign w_accept  = in_valid && in_ready;
   // A same-cycle clear of the accepting warp is seen by the op as a zero accumulator
   assign w_clr_hit = clr_valid && (clr_wid == in_wid);
   assign w_op      = dot8_acc_op_e'(in_op);

   for (genvar g = 0; g < NUM_LANES; g++) begin : g_lane
      assign w_acc_cur[g] = w_clr_hit ? '0 : r_acc[in_wid][g];

      vx_dot8_accum_lane u_lane (
         .i_op       (w_op),
         .i_acc      (w_acc_cur[g]),
         .i_in       (in_data[g*DOT8_ACC_BITS +: DOT8_ACC_BITS]),
         .i_active   (in_tmask[g]),
         .o_next_acc (w_next_acc[g]),
         .o_out      (w_lane_out[g]),
         .o_ovf      (w_ovf[g])
      );

      assign w_out_flat[g*DOT8_ACC_BITS +: DOT8_ACC_BITS] = w_lane_out[g];
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         for (int w = 0; w < NUM_WARPS; w++)
            for (int l = 0; l < NUM_LANES; l++)
               r_acc[w][l] <= '0;
         r_out_valid <= 1'b0;
         r_out_wid   <= '0;
         r_out_tmask <= '0;
         r_out_data  <= '0;
         r_out_ovf   <= '0;
         r_out_tag   <= '0;
         r_acc_count <= '0;
      end else begin
         // Clear first; an accept to the same warp then overwrites with its already-cleared result
         if (clr_valid)
            for (int l = 0; l < NUM_LANES; l++)
               r_acc[clr_wid][l] <= '0;
         if (w_accept)
            for (int l = 0; l < NUM_LANES; l++)
               r_acc[in_wid][l] <= w_next_acc[l];

         if (w_accept) begin
            r_out_valid <= 1'b1;
            r_out_wid   <= in_wid;
            r_out_tmask <= in_tmask;
            r_out_data  <= w_out_flat;
            r_out_ovf   <= w_ovf;
            r_out_tag   <= in_tag;
         end else if (out_ready) begin
            r_out_valid <= 1'b0;
         end

         if (w_accept && (w_op == DOT8_ACC_ACC))
            r_acc_count <= r_acc_count + 32'd1;
      end
   end

   assign out_valid = r_out_valid;
   assign out_wid   = r_out_wid;
   assign out_tmask = r_out_tmask;
   assign out_data  = r_out_data;
   assign out_ovf   = r_out_ovf;
   assign out_tag   = r_out_tag;
   assign acc_count = r_acc_count;

endmodule

// File: tb/tb_vx_dot8_accum.sv
// Directed self-checking bench for vx_dot8_accum with hand-computed expected values.
module tb_vx_dot8_accum;

   localparam int unsigned NL = 4;
   localparam int unsigned NW = 2;
   localparam int unsigned TW = 64;

   logic            clk = 1'b0;
   logic            reset;
   logic            in_valid;
   logic            in_ready;
   logic [1:0]      in_op;
   logic [NW-1:0]   in_wid;
   logic [NL-1:0]   in_tmask;
   logic [NL*32-1:0] in_data;
   logic [TW-1:0]   in_tag;
   logic            clr_valid;
   logic [NW-1:0]   clr_wid;
   logic            out_valid;
   logic            out_ready;
   logic [NW-1:0]   out_wid;
   logic [NL-1:0]   out_tmask;
   logic [NL*32-1:0] out_data;
   logic [NL-1:0]   out_ovf;
   logic [TW-1:0]   out_tag;
   logic [31:0]     acc_count;

   int n_checks = 0;
   int n_errors = 0;

   localparam logic [1:0] OP_PASS = 2'd0, OP_LOAD = 2'd1, OP_ACC = 2'd2, OP_DRAIN = 2'd3;

   vx_dot8_accum dut (
      .clk       (clk),
      .reset     (reset),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_op     (in_op),
      .in_wid    (in_wid),
      .in_tmask  (in_tmask),
      .in_data   (in_data),
      .in_tag    (in_tag),
      .clr_valid (clr_valid),
      .clr_wid   (clr_wid),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_wid   (out_wid),
      .out_tmask (out_tmask),
      .out_data  (out_data),
      .out_ovf   (out_ovf),
      .out_tag   (out_tag),
      .acc_count (acc_count)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   function automatic logic [127:0] rep4(input logic [31:0] v);
      return {v, v, v, v};
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic beat(input logic [1:0] op, input logic [NW-1:0] wid,
                       input logic [NL-1:0] tm, input logic [127:0] data);
      in_valid = 1'b1;
      in_op    = op;
      in_wid   = wid;
      in_tmask = tm;
      in_data  = data;
      in_tag   = {32'hC0DE0000, 30'd0, wid};
   endtask

   initial begin
      reset     = 1'b1;
      in_valid  = 1'b0;
      in_op     = OP_PASS;
      in_wid    = '0;
      in_tmask  = '0;
      in_data   = '0;
      in_tag    = '0;
      clr_valid = 1'b0;
      clr_wid   = '0;
      out_ready = 1'b1;
      tick();
      tick();
      reset = 1'b0;

      check("rst_valid", 128'(out_valid), 128'd0);
      check("rst_count", 128'(acc_count), 128'd0);
      check("rst_data",  out_data, 128'd0);
      check("rst_ovf",   128'(out_ovf), 128'd0);
      check("rst_ready", 128'(in_ready), 128'd1);

      // LOAD 5, ACC 7, ACC -3 back-to-back on warp 0
      beat(OP_LOAD, 2'd0, 4'hF, rep4(32'd5));
      tick();
      check("load_valid", 128'(out_valid), 128'd1);
      check("load_data",  out_data, rep4(32'd5));
      beat(OP_ACC, 2'd0, 4'hF, rep4(32'd7));
      tick();
      check("acc7_data", out_data, rep4(32'd12));
      beat(OP_ACC, 2'd0, 4'hF, rep4(32'hFFFFFFFD));
      tick();
      check("accm3_data", out_data, rep4(32'd9));
      check("accm3_tag",  out_tag, 128'({32'hC0DE0000, 32'd0}));
      in_valid = 1'b0;
      tick();
      check("idle_valid", 128'(out_valid), 128'd0);
      check("count2",     128'(acc_count), 128'd2);

      // Signed overflow on warp 1
      beat(OP_ACC, 2'd1, 4'hF, rep4(32'h7FFFFFFF));
      tick();
      check("w1_max_data", out_data, rep4(32'h7FFFFFFF));
      check("w1_max_ovf",  128'(out_ovf), 128'd0);
      beat(OP_ACC, 2'd1, 4'hF, rep4(32'd1));
      tick();
      check("w1_ovf_data", out_data, rep4(32'h80000000));
      check("w1_ovf",      128'(out_ovf), 128'hF);
      check("w1_wid",      128'(out_wid), 128'd1);
      beat(OP_ACC, 2'd0, 4'hF, rep4(32'd0));
      tick();
      check("w0_untouched", out_data, rep4(32'd9));
      check("ovf_not_sticky", 128'(out_ovf), 128'd0);

      // Partial tmask on warp 2, then DRAIN
      beat(OP_ACC, 2'd2, 4'b0101, rep4(32'd10));
      tick();
      check("mask_data",  out_data, {32'd0, 32'd10, 32'd0, 32'd10});
      check("mask_tmask", 128'(out_tmask), 128'h5);
      beat(OP_DRAIN, 2'd2, 4'hF, rep4(32'd0));
      tick();
      check("drain_data", out_data, {32'd0, 32'd10, 32'd0, 32'd10});
      beat(OP_ACC, 2'd2, 4'hF, rep4(32'd0));
      tick();
      check("drained_zero", out_data, 128'd0);
      check("count7",       128'(acc_count), 128'd7);

      // Backpressure: warp 0 acc 9 -> 10, then hold beat ACC 100
      beat(OP_ACC, 2'd0, 4'hF, rep4(32'd1));
      tick();
      check("pre_stall_data", out_data, rep4(32'd10));
      out_ready = 1'b0;
      beat(OP_ACC, 2'd0, 4'hF, rep4(32'd100));
      for (int i = 0; i < 3; i++) begin
         #1;
         check("stall_ready", 128'(in_ready), 128'd0);
         tick();
         check("stall_valid", 128'(out_valid), 128'd1);
         check("stall_data",  out_data, rep4(32'd10));
      end
      out_ready = 1'b1;
      #1;
      check("release_ready", 128'(in_ready), 128'd1);
      tick();
      check("release_data", out_data, rep4(32'd110));
      in_valid = 1'b0;
      tick();
      check("release_drop", 128'(out_valid), 128'd0);
      check("count9",       128'(acc_count), 128'd9);

      // Clear/accept interaction on warp 3
      beat(OP_LOAD, 2'd3, 4'hF, rep4(32'd100));
      tick();
      check("w3_load", out_data, rep4(32'd100));
      beat(OP_ACC, 2'd3, 4'hF, rep4(32'd4));
      clr_valid = 1'b1;
      clr_wid   = 2'd3;
      tick();
      clr_valid = 1'b0;
      check("clr_same_out", out_data, rep4(32'd4));
      beat(OP_ACC, 2'd3, 4'hF, rep4(32'd0));
      tick();
      check("clr_same_acc", out_data, rep4(32'd4));
      beat(OP_ACC, 2'd0, 4'hF, rep4(32'd1));
      clr_valid = 1'b1;
      clr_wid   = 2'd3;
      tick();
      clr_valid = 1'b0;
      check("clr_diff_w0", out_data, rep4(32'd111));
      beat(OP_ACC, 2'd3, 4'hF, rep4(32'd0));
      tick();
      check("clr_diff_w3", out_data, 128'd0);
      check("count13",     128'(acc_count), 128'd13);

      // Reset with a beat in flight
      beat(OP_ACC, 2'd0, 4'hF, rep4(32'd5));
      tick();
      check("pre_rst_data", out_data, rep4(32'd116));
      in_valid  = 1'b0;
      out_ready = 1'b0;
      reset     = 1'b1;
      tick();
      reset     = 1'b0;
      out_ready = 1'b1;
      check("mid_rst_valid", 128'(out_valid), 128'd0);
      check("mid_rst_count", 128'(acc_count), 128'd0);
      beat(OP_ACC, 2'd0, 4'hF, rep4(32'd6));
      tick();
      check("post_rst_data", out_data, rep4(32'd6));
      check("post_rst_count", 128'(acc_count), 128'd1);
      in_valid = 1'b0;
      tick();

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule

// File: doc/vx_dot8_accum.md
Name: vx_dot8_accum

Overview:
- Per-warp, per-lane 32-bit accumulator stage directly downstream of the dot8 ALU result path, ahead of commit.
- Consumes one packed dot8 result per lane. Applies a per-instruction accumulate op against a register-file of accumulators indexed by warp. Returns the selected value with a one-deep registered valid/ready output.
- Lets a K-loop of dot8 instructions build a full dot product without round-tripping through the GPR file.

Parameters:
- NUM_LANES, 4, lanes per result beat
- NUM_WARPS, 4, warps with private accumulator sets (NW_WIDTH = max(1, clog2(NUM_WARPS)))
- TAG_WIDTH, 64, opaque sideband (uuid/PC/rd/wb/pid/sop/eop) carried unchanged

Ports:
- clk  in  1  clock
- reset  in  1  synchronous active-high reset
- in_valid  in  1  result beat valid
- in_ready  out  1  beat accepted when in_valid && in_ready
- in_op  in  2  0=PASS, 1=LOAD, 2=ACC, 3=DRAIN
- in_wid  in  NW_WIDTH  warp id
- in_tmask  in  NUM_LANES  active lanes
- in_data  in  NUM_LANES*32  dot8 results, lane i at [32i+:32]
- in_tag  in  TAG_WIDTH  sideband
- clr_valid  in  1  clear all lanes of one warp's accumulators
- clr_wid  in  NW_WIDTH  warp to clear
- out_valid  out  1  result valid
- out_ready  in  1  downstream accept
- out_wid  out  NW_WIDTH  warp id
- out_tmask  out  NUM_LANES  tmask
- out_data  out  NUM_LANES*32  result per lane
- out_ovf  out  NUM_LANES  signed overflow in this beat's ACC add
- out_tag  out  TAG_WIDTH  sideband
- acc_count  out  32  number of accepted ACC beats, wraps

Behaviour:
- Reset (synchronous, active-high): all accumulators 0, out_valid=0, out_ovf=0, acc_count=0. out_data, out_wid, out_tmask and out_tag are 0 after reset.
- Handshake: in_ready = !out_valid || out_ready. Latency is exactly 1 cycle from accept to out_valid. Back-to-back throughput is 1 beat/cycle while out_ready=1.
- out_* holds stable while out_valid && !out_ready.
- All accumulator updates occur on the accept edge and only for lanes with in_tmask[i]=1. Inactive lanes leave the accumulator unchanged and output 0 with ovf 0.
- PASS: out = in_data; accumulator untouched.
- LOAD: acc = in_data; out = in_data.
- ACC: sum = acc + in_data, modulo 2^32; acc = sum; out = sum.
  - ovf[i] = (acc[31]==in[31]) && (sum[31]!=acc[31]).
  - acc_count increments by 1 per accepted ACC beat, regardless of tmask.
- DRAIN: out = acc + in_data, modulo 2^32; acc = 0. ovf is computed as for ACC.
- Back-to-back beats to the same warp must see the previous beat's update. Accumulators are flops read in the accept cycle, so no bypass stall is allowed.
- Clear: clr_valid zeroes all lanes of warp clr_wid at the clock edge. It is independent of the handshake and never stalls.
- Simultaneous clear and accept to the same warp: clear applies first, then the op. ACC and DRAIN therefore add to 0, and the output equals in_data.
- Clear and accept to different warps: both take effect in the same cycle.
- Reset mid-stream: the in-flight output beat is discarded and accumulators are zeroed.
- out_ovf is per-beat, not sticky.

Decomposition:
- VX_gpu_pkg holds:
  - op encodings DOT8_ACC_PASS/LOAD/ACC/DRAIN, 2 bits;
  - the localparam DOT8_ACC_BITS=32.
- One sub-module, vx_dot8_accum_lane, per lane. It is combinational:
  - inputs: op, acc, in, active;
  - outputs: next_acc, out, ovf.
- The top module holds:
  - the accumulator array [NUM_WARPS][NUM_LANES];
  - the clear/op priority;
  - the output register and handshake.

Test Plan:
- Warp 0, tmask=4'hF: LOAD 5, ACC 7, ACC -3 (0xFFFFFFFD) back-to-back, out_ready=1 -> outputs 5, 12, 9 on consecutive cycles, each 1 cycle after accept; acc_count=2.
- Warp 1 ACC 0x7FFFFFFF then ACC 1 -> out 0x80000000, out_ovf=4'hF; warp 0 accumulators unchanged.
- tmask=4'b0101, ACC 10 on warp 2 starting from 0 -> lanes 0 and 2 output 10, lanes 1 and 3 output 0; a following DRAIN 0 with tmask=4'hF -> 10,0,10,0, then accumulators are all 0.
- out_ready=0 for 3 cycles with a beat pending -> in_ready=0, out_* stable, no accumulator change from the held input; release -> the next beat is accepted the same cycle.
- clr_valid for warp 3 in the same cycle as ACC 4 to warp 3 holding 100 -> out=4, acc=4; clr on warp 3 while ACC to warp 0 -> both applied.
- Assert reset while out_valid=1 with non-zero accumulators -> next cycle out_valid=0, acc_count=0; a subsequent ACC 6 outputs 6.
